mod_reduce_barrett: RTL and testbench

- Pipelined Barrett modular reduction stage placed directly downstream of the FHE ALU multiplier.
- Consumes the 2*DATA_SIZE-bit product and its valid, and returns product mod q at DATA_SIZE bits.
- q and the precomputed constant mu = floor(2^(2*DATA_SIZE)/q) are loaded through a config port.
- Each in-flight operand carries its own q/mu snapshot, so reconfiguration never corrupts results already in the pipe.

---
 rtl/mod_reduce_barrett.sv | 151 +++++++++++++++
 tb/tb_mod_reduce_barrett.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/mod_reduce_barrett.sv
// Barrett reduction of a 2N-bit product to N bits mod q, with per-item q/mu snapshots.
// Latency: 5 cycles, fully pipelined. Backpressure: none; the pipe advances every cycle.
`ifndef FSIZE
`define FSIZE 8
`endif

module mod_reduce_barrett #(
    parameter int DATA_SIZE = `FSIZE
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     cfg_we,
    input  logic [DATA_SIZE-1:0]     cfg_q,
    input  logic [DATA_SIZE:0]       cfg_mu,
    input  logic                     in_valid,
    input  logic [2*DATA_SIZE-1:0]   in_data,
    output logic                     out_valid,
    output logic [DATA_SIZE-1:0]     out_data,
    output logic                     out_ovf
);

    localparam int N       = DATA_SIZE;
    localparam int LATENCY = 5;

    logic [N-1:0]   q_act;
    logic [N:0]     mu_act;

    logic           s1_vld;
    logic [N:0]     s1_q1;
    logic [N+1:0]   s1_x;
    logic [N-1:0]   s1_q;
    logic [N:0]     s1_mu;

    logic           s2_vld;
    logic [N:0]     s2_q3;
    logic [N+1:0]   s2_x;
    logic [N-1:0]   s2_q;

    logic           s3_vld;
    logic [N+1:0]   s3_r0;
    logic [N-1:0]   s3_q;

    logic           s4_vld;
    logic [N+1:0]   s4_r1;
    logic [N-1:0]   s4_q;

    logic           s5_vld;
    logic [N+1:0]   s5_r2;
    logic [N-1:0]   s5_q;

    logic [2*N+1:0] q1_w;
    logic [2*N+1:0] mu_w;
    logic [2*N+1:0] q2_c;
    logic [N:0]     q3_c;
    logic [N+1:0]   q3_w;
    logic [N+1:0]   s2_q_w;
    logic [N+1:0]   p_c;
    logic [N+1:0]   r0_c;
    logic [N+1:0]   s3_q_w;
    logic [N+1:0]   r1_c;
    logic [N+1:0]   s4_q_w;
    logic [N+1:0]   r2_c;
    logic [N+1:0]   s5_q_w;

    // Estimate of floor(x/q): top N+1 bits of q1*mu.
    assign q1_w = {{(N+1){1'b0}}, s1_q1};
    assign mu_w = {{(N+1){1'b0}}, s1_mu};
    assign q2_c = q1_w * mu_w;
    assign q3_c = q2_c[2*N+1:N+1];

    // Remainder only needs N+2 bits: under x < q^2 the true difference is below 3q.
    assign q3_w   = {1'b0, s2_q3};
    assign s2_q_w = {2'b00, s2_q};
    assign p_c    = q3_w * s2_q_w;
    assign r0_c   = s2_x - p_c;

    assign s3_q_w = {2'b00, s3_q};
    assign r1_c   = (s3_r0 >= s3_q_w) ? (s3_r0 - s3_q_w) : s3_r0;

    assign s4_q_w = {2'b00, s4_q};
    assign r2_c   = (s4_r1 >= s4_q_w) ? (s4_r1 - s4_q_w) : s4_r1;

    assign s5_q_w = {2'b00, s5_q};

    always_ff @(posedge clk) begin
        if (rst) begin
            q_act     <= '0;
            mu_act    <= '0;
            s1_vld    <= 1'b0;
            s1_q1     <= '0;
            s1_x      <= '0;
            s1_q      <= '0;
            s1_mu     <= '0;
            s2_vld    <= 1'b0;
            s2_q3     <= '0;
            s2_x      <= '0;
            s2_q      <= '0;
            s3_vld    <= 1'b0;
            s3_r0     <= '0;
            s3_q      <= '0;
            s4_vld    <= 1'b0;
            s4_r1     <= '0;
            s4_q      <= '0;
            s5_vld    <= 1'b0;
            s5_r2     <= '0;
            s5_q      <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_ovf   <= 1'b0;
        end else begin
            if (cfg_we) begin
                q_act  <= cfg_q;
                mu_act <= cfg_mu;
            end

            // Items sampled this edge take the modulus active before any cfg write.
            s1_vld <= in_valid;
            if (in_valid) begin
                s1_q1 <= in_data[2*N-1:N-1];
                s1_x  <= in_data[N+1:0];
                s1_q  <= q_act;
                s1_mu <= mu_act;
            end

            s2_vld <= s1_vld;
            s2_q3  <= q3_c;
            s2_x   <= s1_x;
            s2_q   <= s1_q;

            s3_vld <= s2_vld;
            s3_r0  <= r0_c;
            s3_q   <= s2_q;

            s4_vld <= s3_vld;
            s4_r1  <= r1_c;
            s4_q   <= s3_q;

            s5_vld <= s4_vld;
            s5_r2  <= r2_c;
            s5_q   <= s4_q;

            // Result registers hold the last valid item so idle bubbles never raise ovf.
            out_valid <= s5_vld;
            if (s5_vld) begin
                out_data <= s5_r2[N-1:0];
                out_ovf  <= (s5_r2 >= s5_q_w);
            end
        end
    end

endmodule

// File: tb/tb_mod_reduce_barrett.sv
// Directed and randomized bench for mod_reduce_barrett at DATA_SIZE=8.
module tb_mod_reduce_barrett;

    localparam int N   = 8;
    localparam int LAT = 5;

    logic             clk = 1'b0;
    logic             rst;
    logic             cfg_we;
    logic [N-1:0]     cfg_q;
    logic [N:0]       cfg_mu;
    logic             in_valid;
    logic [2*N-1:0]   in_data;
    logic             out_valid;
    logic [N-1:0]     out_data;
    logic             out_ovf;

    typedef struct {
        logic       v;
        logic [7:0] d;
        logic       o;
    } exp_t;

    exp_t exp_q[$];
    int   n_pass  = 0;
    int   n_total = 0;
    int   mq      = 0;
    int   mmu     = 0;

    mod_reduce_barrett #(.DATA_SIZE(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .cfg_we    (cfg_we),
        .cfg_q     (cfg_q),
        .cfg_mu    (cfg_mu),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ovf   (out_ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_total++;
        assert (got === want) n_pass++;
        else $error("FAIL %s got %0d expected %0d", tag, got, want);
    endtask

    // Exact x mod q when the Barrett preconditions hold; otherwise the
    // arithmetic estimate with two corrections and an N+2-bit wrap.
    function automatic void model(input int x, input int q, input int mu,
                                  output logic [7:0] d, output logic o);
        int q3;
        int r;
        if (q > 1 && mu == 65536 / q && x < q * q) begin
            r = x % q;
            d = r[7:0];
            o = 1'b0;
        end else begin
            q3 = ((x >> 7) * mu) >> 9;
            r  = (x - q3 * q) & 1023;
            if (r >= q) r = r - q;
            if (r >= q) r = r - q;
            o = (r >= q);
            d = r[7:0];
        end
    endfunction

    // One clock: record what the sampled inputs should produce LAT cycles later,
    // then compare the output due now.
    task automatic tick(input string tag, input logic ev, input logic [7:0] ed,
                        input logic eo, input logic idle);
        exp_t e;
        exp_t h;
        @(posedge clk);
        if (rst) begin
            exp_q.delete();
            for (int k = 0; k < LAT; k++) begin
                e.v = 1'b0; e.d = 8'd0; e.o = 1'b0;
                exp_q.push_back(e);
            end
            mq  = 0;
            mmu = 0;
        end else begin
            e.v = ev; e.d = ed; e.o = eo;
            exp_q.push_back(e);
            if (cfg_we) begin
                mq  = int'(cfg_q);
                mmu = int'(cfg_mu);
            end
        end
        #1;
        if (rst) begin
            chk({tag, "_rst_vld"}, 32'(out_valid), 32'd0);
            chk({tag, "_rst_dat"}, 32'(out_data), 32'd0);
            chk({tag, "_rst_ovf"}, 32'(out_ovf), 32'd0);
        end else begin
            h = exp_q.pop_front();
            chk({tag, "_vld"}, 32'(out_valid), 32'(h.v));
            if (h.v) begin
                chk({tag, "_dat"}, 32'(out_data), 32'(h.d));
                chk({tag, "_ovf"}, 32'(out_ovf), 32'(h.o));
            end else if (idle) begin
                chk({tag, "_idle_dat"}, 32'(out_data), 32'd0);
                chk({tag, "_idle_ovf"}, 32'(out_ovf), 32'd0);
            end
        end
    endtask

    task automatic set_in(input logic v, input int x);
        in_valid = v;
        in_data  = 16'(x);
    endtask

    task automatic bubbles(input string tag, input int n);
        set_in(1'b0, 0);
        cfg_we = 1'b0;
        for (int k = 0; k < n; k++) tick(tag, 1'b0, 8'd0, 1'b0, 1'b0);
    endtask

    initial begin
        logic [7:0] ed;
        logic       eo;
        int         a;
        int         b;
        int         nq;

        rst = 1'b1; cfg_we = 1'b0; cfg_q = '0; cfg_mu = '0;
        set_in(1'b0, 0);
        repeat (3) tick("reset", 1'b0, 8'd0, 1'b0, 1'b0);

        rst = 1'b0;
        cfg_we = 1'b1; cfg_q = 8'd251; cfg_mu = 9'd261;
        tick("idle", 1'b0, 8'd0, 1'b0, 1'b1);
        cfg_we = 1'b0;
        for (int k = 0; k < 6; k++) tick("idle", 1'b0, 8'd0, 1'b0, 1'b1);

        set_in(1'b1, 62500); tick("exact_62500", 1'b1, 8'd1,   1'b0, 1'b0);
        set_in(1'b1, 0);     tick("exact_0",     1'b1, 8'd0,   1'b0, 1'b0);
        set_in(1'b1, 251);   tick("exact_251",   1'b1, 8'd0,   1'b0, 1'b0);
        set_in(1'b1, 250);   tick("exact_250",   1'b1, 8'd250, 1'b0, 1'b0);
        bubbles("drain1", 6);

        set_in(1'b1, 65535); tick("above_q2", 1'b1, 8'd24, 1'b0, 1'b0);
        bubbles("drain2", 6);

        cfg_we = 1'b1; cfg_q = 8'd251; cfg_mu = 9'd0;
        tick("cfg_bad_mu", 1'b0, 8'd0, 1'b0, 1'b0);
        cfg_we = 1'b0;
        set_in(1'b1, 1000); tick("bad_mu", 1'b1, 8'd242, 1'b1, 1'b0);
        cfg_we = 1'b1; cfg_mu = 9'd261;
        bubbles("drain3", 6);
        cfg_we = 1'b1; cfg_q = 8'd251; cfg_mu = 9'd261;
        tick("cfg_restore", 1'b0, 8'd0, 1'b0, 1'b0);

        // Old item sees q=251 (62500 mod 241 would be 81); next item sees q=241.
        set_in(1'b1, 62500);
        cfg_we = 1'b1; cfg_q = 8'd241; cfg_mu = 9'd271;
        tick("reconf_old", 1'b1, 8'd1, 1'b0, 1'b0);
        cfg_we = 1'b0;
        set_in(1'b1, 50000); tick("reconf_new", 1'b1, 8'd113, 1'b0, 1'b0);
        bubbles("drain4", 6);
        cfg_we = 1'b1; cfg_q = 8'd251; cfg_mu = 9'd261;
        tick("cfg_restore2", 1'b0, 8'd0, 1'b0, 1'b0);
        cfg_we = 1'b0;

        set_in(1'b1, 1000); tick("midrst_a", 1'b1, 8'd247, 1'b0, 1'b0);
        set_in(1'b1, 2000); tick("midrst_b", 1'b1, 8'd243, 1'b0, 1'b0);
        set_in(1'b1, 3000); rst = 1'b1;
        tick("midrst_c", 1'b0, 8'd0, 1'b0, 1'b0);
        rst = 1'b0;
        set_in(1'b0, 0);
        for (int k = 0; k < 10; k++) tick("midrst_quiet", 1'b0, 8'd0, 1'b0, 1'b0);
        cfg_we = 1'b1; cfg_q = 8'd251; cfg_mu = 9'd261;
        tick("cfg_restore3", 1'b0, 8'd0, 1'b0, 1'b0);
        cfg_we = 1'b0;

        for (int i = 0; i < 10000; i++) begin
            cfg_we = 1'b0;
            if ($urandom_range(199) == 0) begin
                nq     = int'($urandom_range(255, 129));
                cfg_we = 1'b1;
                cfg_q  = 8'(nq);
                cfg_mu = 9'(65536 / nq);
            end
            a = int'($urandom_range(mq - 1));
            b = int'($urandom_range(mq - 1));
            if ($urandom_range(3) != 0) begin
                set_in(1'b1, a * b);
                model(a * b, mq, mmu, ed, eo);
                tick("rand", 1'b1, ed, eo, 1'b0);
            end else begin
                set_in(1'b0, a * b);
                tick("rand_bub", 1'b0, 8'd0, 1'b0, 1'b0);
            end
        end
        bubbles("drain_rand", 6);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
